// File: rtl/i2c_codec_reg_slave_if.sv
// i2c_codec_reg_slave_if
//   Register-write side of the codec register target.
//   REG_ADDR  : 7-bit register address of the last completed write
//   REG_DATA  : 9-bit register value of the last completed write
//   REG_VALID : one-cycle pulse when REG_ADDR/REG_DATA take a new value
//   BUSY      : a frame addressed to this target is in progress
//   ERROR     : one-cycle pulse on a malformed matched frame
//   Modports: slave (driven by the target), master (observer/consumer).
interface i2c_codec_reg_slave_if;
    logic [6:0] REG_ADDR;
    logic [8:0] REG_DATA;
    logic       REG_VALID;
    logic       BUSY;
    logic       ERROR;

    modport slave  (output REG_ADDR, REG_DATA, REG_VALID, BUSY, ERROR);
    modport master (input  REG_ADDR, REG_DATA, REG_VALID, BUSY, ERROR);
endinterface

// File: rtl/i2c_codec_reg_slave.sv
// i2c_codec_reg_slave
//   Write-only I2C target for codec-style 3-byte register writes
//   {dev_addr+W, byte_hi, byte_lo}. SCL/SDA are oversampled on CLOCK;
//   each complete write is unpacked into a 7-bit address (byte_hi[7:1])
//   and a 9-bit value ({byte_hi[0], byte_lo}).
// Ports
//   CLOCK    : system clock, at least 8x the SCL rate
//   RESET_N  : synchronous active-low reset
//   I2C_SCLK : I2C clock from the master
//   I2C_SDAT : I2C data; this block only ever drives 0 or releases (z)
//   regs     : register-write outputs (see i2c_codec_reg_slave_if)
// Build option
//   I2C_GLITCH_FILTER_EN : when defined, a 3-sample majority filter
//   follows the synchronisers (2 extra cycles, rejects 1-cycle pulses).
module i2c_codec_reg_slave #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        CLOCK,
    input  logic                        RESET_N,
    input  logic                        I2C_SCLK,
    inout  wire                         I2C_SDAT,
    i2c_codec_reg_slave_if.slave        regs
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_f, sda_f, scl_p, sda_p;
    logic                   scl_rise, scl_fall, start_c, stop_c;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], I2C_SDAT};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_s, sda_s;
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_s};
            sda_hist <= {sda_hist[0], sda_s};
            scl_f    <= (scl_s & scl_hist[0]) | (scl_s & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_s & sda_hist[0]) | (sda_s & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_sync[SYNC_STAGES-1];
    assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    // START/STOP need SCL high on both samples so an SCL edge coinciding
    // with an SDA edge is never mistaken for a bus condition.
    assign scl_rise = scl_f & ~scl_p;
    assign scl_fall = ~scl_f & scl_p;
    assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

    state_t     state, state_n;
    logic [6:0] shreg, shreg_n;
    logic [7:0] hi_byte, hi_byte_n, byte_in;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [1:0] byte_cnt, byte_cnt_n;
    logic       ack_phase, ack_phase_n, nack, nack_n;
    logic       load, err;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       reg_valid, error;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            shreg     <= '0;
            hi_byte   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            ack_phase <= 1'b0;
            nack      <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            reg_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            hi_byte   <= hi_byte_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            ack_phase <= ack_phase_n;
            nack      <= nack_n;
            reg_valid <= load;
            error     <= err;
            if (load) begin
                reg_addr <= hi_byte[7:1];
                reg_data <= {hi_byte[0], byte_in};
            end
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        hi_byte_n   = hi_byte;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        ack_phase_n = ack_phase;
        nack_n      = nack;
        load        = 1'b0;
        err         = 1'b0;
        byte_in     = {shreg, sda_f};

        if (start_c) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            byte_cnt_n  = '0;
            ack_phase_n = 1'b0;
            nack_n      = 1'b0;
        end else if (stop_c) begin
            // A matched frame carrying only byte_hi is incomplete.
            if ((state == DATA || state == DATA_ACK) && byte_cnt == 2'd1)
                err = 1'b1;
            state_n     = IDLE;
            ack_phase_n = 1'b0;
            nack_n      = 1'b0;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in[6:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ADDR) begin
                                state_n = (byte_in == {DEV_ADDR, 1'b0}) ? ADDR_ACK : IGNORE;
                            end else begin
                                // Third and later bytes still walk the ACK slot
                                // (with SDA released) to stay bit-aligned.
                                state_n = DATA_ACK;
                                case (byte_cnt)
                                    2'd0: begin
                                        hi_byte_n  = byte_in;
                                        byte_cnt_n = 2'd1;
                                    end
                                    2'd1: begin
                                        load       = 1'b1;
                                        byte_cnt_n = 2'd2;
                                    end
                                    2'd2: begin
                                        err        = 1'b1;
                                        nack_n     = 1'b1;
                                        byte_cnt_n = 2'd3;
                                    end
                                    default: nack_n = 1'b1;
                                endcase
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // First SCL fall opens the slot, second one closes it.
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase_n = 1'b1;
                        end else begin
                            ack_phase_n = 1'b0;
                            nack_n      = 1'b0;
                            state_n     = DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign I2C_SDAT       = (ack_phase && !nack) ? 1'b0 : 1'bz;
    assign regs.REG_ADDR  = reg_addr;
    assign regs.REG_DATA  = reg_data;
    assign regs.REG_VALID = reg_valid;
    assign regs.ERROR     = error;
    assign regs.BUSY      = (state == ADDR_ACK) || (state == DATA) || (state == DATA_ACK);

endmodule
